// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: stall, bubble, flush and memory-freeze sequencing.
// Holds PC/IF-ID for non-forwardable hazards, counts down multi-cycle
// stalls, freezes the pipe while dmem withholds ack, keeps statistics.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   IDRs1, IDRs2         ID source registers
//   id_uses_rs1/rs2      ID instruction reads the source
//   id_branch            ID holds a branch
//   id_branch_taken      ID branch resolved taken
//   EXRegisterRd         EX destination
//   EXRegWrite           EX writes a register
//   EXMemRead            EX is a load
//   MemRegisterRd        MEM destination
//   MemMemRead           MEM is a load
//   dmem_req, dmem_ack   data memory request / completion
//   pc_write             PC update enable
//   if_id_write          IF/ID update enable
//   if_id_flush          clear IF/ID
//   id_ex_bubble         load NOP into ID/EX
//   id_ex_write          ID/EX update enable
//   ex_mem_write         EX/MEM update enable
//   mem_wb_bubble        load NOP into MEM/WB
//   stall_active         multi-cycle stall in progress
//   stall_cycles         saturating stall+freeze cycle count
//   flush_count          saturating flush count
//   mem_timeout          sticky memory wait timeout

module hazard_stall_controller #(
    parameter int AddressSize = 5,
    parameter int CntWidth    = 16,
    parameter int MemTimeout  = 64
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [AddressSize-1:0] IDRs1,
    input  logic [AddressSize-1:0] IDRs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_branch,
    input  logic                   id_branch_taken,
    input  logic [AddressSize-1:0] EXRegisterRd,
    input  logic                   EXRegWrite,
    input  logic                   EXMemRead,
    input  logic [AddressSize-1:0] MemRegisterRd,
    input  logic                   MemMemRead,
    input  logic                   dmem_req,
    input  logic                   dmem_ack,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   mem_wb_bubble,
    output logic                   stall_active,
    output logic [CntWidth-1:0]    stall_cycles,
    output logic [CntWidth-1:0]    flush_count,
    output logic                   mem_timeout
);

    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] HAZ = 1'b1;

    localparam int WaitWidth = (MemTimeout > 2) ? $clog2(MemTimeout) : 1;
    localparam logic [WaitWidth-1:0] WaitLast = WaitWidth'(MemTimeout - 1);
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [0:0]           state;
    logic [1:0]           cnt;
    logic [WaitWidth-1:0] wait_cnt;

    logic rs1_ex;
    logic rs2_ex;
    logic rs1_mem;
    logic rs2_mem;
    logic [1:0] n_rs1;
    logic [1:0] n_rs2;
    logic [1:0] n_req;
    logic freeze;
    logic stall;
    logic flush;

    // Live source: used, nonzero and matching the producer's destination.
    always_comb begin
        rs1_ex  = id_uses_rs1 && (IDRs1 != '0) && (IDRs1 == EXRegisterRd);
        rs2_ex  = id_uses_rs2 && (IDRs2 != '0) && (IDRs2 == EXRegisterRd);
        rs1_mem = id_uses_rs1 && (IDRs1 != '0) && (IDRs1 == MemRegisterRd);
        rs2_mem = id_uses_rs2 && (IDRs2 != '0) && (IDRs2 == MemRegisterRd);
    end

    // Branches compare in ID, so they also wait on ALU results in EX and
    // on loads in MEM; ordinary consumers only wait on a load in EX.
    always_comb begin
        n_rs1 = 2'd0;
        if (rs1_ex && EXMemRead) begin
            n_rs1 = id_branch ? 2'd2 : 2'd1;
        end else if (rs1_ex && EXRegWrite && id_branch) begin
            n_rs1 = 2'd1;
        end else if (rs1_mem && MemMemRead && id_branch) begin
            n_rs1 = 2'd1;
        end
    end

    always_comb begin
        n_rs2 = 2'd0;
        if (rs2_ex && EXMemRead) begin
            n_rs2 = id_branch ? 2'd2 : 2'd1;
        end else if (rs2_ex && EXRegWrite && id_branch) begin
            n_rs2 = 2'd1;
        end else if (rs2_mem && MemMemRead && id_branch) begin
            n_rs2 = 2'd1;
        end
    end

    always_comb begin
        n_req = (n_rs1 > n_rs2) ? n_rs1 : n_rs2;
    end

    // The ack cycle is not frozen: the pipe advances as memory completes.
    always_comb begin
        freeze = dmem_req && !dmem_ack;
        stall  = !freeze && ((state == HAZ) || (n_req != 2'd0));
        flush  = !freeze && (state == RUN) && (n_req == 2'd0)
                 && id_branch && id_branch_taken;
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        unique case (1'b1)
            freeze: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
            end
            stall: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            flush: begin
                if_id_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Once in HAZ the remaining count is trusted; the ID decision is not
    // re-evaluated because the producer has moved down the pipe.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else if (!freeze) begin
            if (state == RUN) begin
                if (n_req != 2'd0) begin
                    cnt <= n_req - 2'd1;
                    if (n_req == 2'd2) begin
                        state <= HAZ;
                    end
                end
            end else begin
                cnt <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                if (cnt <= 2'd1) begin
                    state <= RUN;
                end
            end
        end
    end

    assign stall_active = (state == HAZ);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((stall || freeze) && (stall_cycles != CntMax)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush && (flush_count != CntMax)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    // wait_cnt holds at its last value so a long wait cannot wrap.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (freeze) begin
            if (wait_cnt == WaitLast) begin
                mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule
